// File: rtl/approx_adder_err_monitor_pkg.sv
// rtl/approx_adder_err_monitor_pkg.sv - shared types and default widths for the approximate-adder error monitor
package approx_mon_pkg;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_MASK_W = 3;
    localparam int DEF_CNT_W  = 16;
    localparam int DEF_ACC_W  = 24;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } mon_state_e;

    // Saturating add of an error distance into the running ED sum.
    function automatic logic [DEF_ACC_W-1:0] sat_add_ed(input logic [DEF_ACC_W-1:0] acc,
                                                        input logic [DEF_ACC_W-1:0] ed);
        logic [DEF_ACC_W:0] wide;
        wide = {1'b0, acc} + {1'b0, ed};
        return wide[DEF_ACC_W] ? {DEF_ACC_W{1'b1}} : wide[DEF_ACC_W-1:0];
    endfunction

endpackage

// File: rtl/approx_adder_err_monitor_if.sv
// rtl/approx_adder_err_monitor_if.sv - sample input and report output handshake bundle
interface approx_adder_err_monitor_if
    import approx_mon_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int MASK_W = DEF_MASK_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int ACC_W  = DEF_ACC_W
);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in1;
    logic [WIDTH-1:0]  in2;
    logic [MASK_W-1:0] mask;
    logic [WIDTH:0]    approx_sum;

    logic              rpt_valid;
    logic              rpt_ready;
    logic [CNT_W-1:0]  rpt_samples;
    logic [CNT_W-1:0]  rpt_err_cnt;
    logic [ACC_W-1:0]  rpt_ed_sum;
    logic [WIDTH:0]    rpt_ed_max;
    logic [MASK_W-1:0] rpt_mask;
    logic              rpt_mask_chg;

    // master: sample producer / report consumer; slave: the monitor
    modport master (
        output in_valid, in1, in2, mask, approx_sum, rpt_ready,
        input  in_ready, rpt_valid, rpt_samples, rpt_err_cnt, rpt_ed_sum,
               rpt_ed_max, rpt_mask, rpt_mask_chg
    );

    modport slave (
        input  in_valid, in1, in2, mask, approx_sum, rpt_ready,
        output in_ready, rpt_valid, rpt_samples, rpt_err_cnt, rpt_ed_sum,
               rpt_ed_max, rpt_mask, rpt_mask_chg
    );

endinterface

// File: rtl/approx_adder_err_monitor_ed_calc.sv
// rtl/approx_adder_err_monitor_ed_calc.sv - exact sum and absolute error distance of one adder sample
module approx_ed_calc #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH:0]   approx_sum,
    output logic [WIDTH:0]   ed,
    output logic             err
);
    logic [WIDTH:0] exact;

    always_comb begin
        exact = {1'b0, in1} + {1'b0, in2};
        if (exact >= approx_sum) begin
            ed = exact - approx_sum;
        end else begin
            ed = approx_sum - exact;
        end
        err = (ed != '0);
    end

endmodule

// File: rtl/approx_adder_err_monitor.sv
// rtl/approx_adder_err_monitor.sv - windowed accuracy statistics for the masked approximate adder
module approx_adder_err_monitor
    import approx_mon_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int MASK_W = DEF_MASK_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [CNT_W-1:0]              win_len,
    output logic                          busy,
    approx_adder_err_monitor_if.slave     bus
);
    localparam int SUM_W = ACC_W + 1;

    mon_state_e        state_q;
    mon_state_e        state_d;

    logic [CNT_W-1:0]  win_len_q;
    logic [CNT_W-1:0]  acc_cnt_q;

    logic              s1_valid_q;
    logic [WIDTH:0]    s1_ed_q;
    logic              s1_err_q;
    logic [MASK_W-1:0] s1_mask_q;

    logic [CNT_W-1:0]  samp_cnt_q;
    logic [CNT_W-1:0]  err_cnt_q;
    logic [ACC_W-1:0]  ed_sum_q;
    logic [WIDTH:0]    ed_max_q;
    logic [MASK_W-1:0] mask_q;
    logic              mask_chg_q;

    logic [WIDTH:0]    ed_c;
    logic              err_c;
    logic              accept;
    logic              last_accept;
    logic              open_win;
    logic [SUM_W-1:0]  ed_sum_wide;

    approx_ed_calc #(.WIDTH(WIDTH)) u_ed_calc (
        .in1        (bus.in1),
        .in2        (bus.in2),
        .approx_sum (bus.approx_sum),
        .ed         (ed_c),
        .err        (err_c)
    );

    assign accept      = (state_q == ACCUM) && bus.in_valid;
    assign last_accept = accept && ((acc_cnt_q + CNT_W'(1)) == win_len_q);
    assign open_win    = (state_q == IDLE) && start && (win_len != '0);
    assign ed_sum_wide = {1'b0, ed_sum_q} + SUM_W'(s1_ed_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.rpt_valid = 1'b0;
        busy          = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (open_win) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                bus.in_ready = 1'b1;
                if (last_accept) begin
                    state_d = DRAIN;
                end
            end
            // The final sample is still in stage 1 here; one cycle lets it land in the accumulators.
            DRAIN: begin
                state_d = REPORT;
            end
            REPORT: begin
                bus.rpt_valid = 1'b1;
                if (bus.rpt_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_len_q  <= '0;
            acc_cnt_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_ed_q    <= '0;
            s1_err_q   <= 1'b0;
            s1_mask_q  <= '0;
            samp_cnt_q <= '0;
            err_cnt_q  <= '0;
            ed_sum_q   <= '0;
            ed_max_q   <= '0;
            mask_q     <= '0;
            mask_chg_q <= 1'b0;
        end else if (open_win) begin
            win_len_q  <= win_len;
            acc_cnt_q  <= '0;
            s1_valid_q <= 1'b0;
            samp_cnt_q <= '0;
            err_cnt_q  <= '0;
            ed_sum_q   <= '0;
            ed_max_q   <= '0;
            mask_q     <= '0;
            mask_chg_q <= 1'b0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                acc_cnt_q <= acc_cnt_q + CNT_W'(1);
                s1_ed_q   <= ed_c;
                s1_err_q  <= err_c;
                s1_mask_q <= bus.mask;
            end
            if (s1_valid_q) begin
                samp_cnt_q <= samp_cnt_q + CNT_W'(1);
                if (s1_err_q) begin
                    err_cnt_q <= err_cnt_q + CNT_W'(1);
                end
                ed_sum_q <= ed_sum_wide[ACC_W] ? {ACC_W{1'b1}} : ed_sum_wide[ACC_W-1:0];
                if (s1_ed_q > ed_max_q) begin
                    ed_max_q <= s1_ed_q;
                end
                // Empty sample count marks the first sample: it defines the reference mask.
                if (samp_cnt_q == '0) begin
                    mask_q <= s1_mask_q;
                end else if (s1_mask_q != mask_q) begin
                    mask_chg_q <= 1'b1;
                end
            end
        end
    end

    assign bus.rpt_samples  = samp_cnt_q;
    assign bus.rpt_err_cnt  = err_cnt_q;
    assign bus.rpt_ed_sum   = ed_sum_q;
    assign bus.rpt_ed_max   = ed_max_q;
    assign bus.rpt_mask     = mask_q;
    assign bus.rpt_mask_chg = mask_chg_q;

endmodule

// File: tb/tb_approx_adder_err_monitor.sv
// tb/tb_approx_adder_err_monitor.sv - self-checking bench for approx_adder_err_monitor
module tb_approx_adder_err_monitor;
    import approx_mon_pkg::*;

    localparam int WIDTH  = 4;
    localparam int MASK_W = 3;
    localparam int CNT_W  = 16;
    localparam int ACC_W  = 24;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] win_len;
    logic             busy;

    approx_adder_err_monitor_if #(
        .WIDTH(WIDTH), .MASK_W(MASK_W), .CNT_W(CNT_W), .ACC_W(ACC_W)
    ) bus ();

    approx_adder_err_monitor #(
        .WIDTH(WIDTH), .MASK_W(MASK_W), .CNT_W(CNT_W), .ACC_W(ACC_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .win_len (win_len),
        .busy    (busy),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    int q1[$];
    int q2[$];
    int qm[$];
    int qa[$];

    longint exp_samples, exp_err, exp_sum, exp_max, exp_mask, exp_chg;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int a, input int b, input int m, input int apx);
        q1.push_back(a);
        q2.push_back(b);
        qm.push_back(m);
        qa.push_back(apx);
    endtask

    task automatic clear_model();
        q1.delete();
        q2.delete();
        qm.delete();
        qa.delete();
    endtask

    // Window statistics straight from the list of samples sent.
    task automatic compute_expected();
        longint ed;
        exp_samples = q1.size();
        exp_err = 0;
        exp_sum = 0;
        exp_max = 0;
        exp_mask = (qm.size() > 0) ? qm[0] : 0;
        exp_chg = 0;
        foreach (q1[i]) begin
            ed = q1[i] + q2[i] - qa[i];
            if (ed < 0) ed = -ed;
            if (ed != 0) exp_err++;
            exp_sum += ed;
            if (ed > exp_max) exp_max = ed;
            if (qm[i] != exp_mask) exp_chg = 1;
        end
        if (exp_sum > 64'hFF_FFFF) exp_sum = 64'hFF_FFFF;
    endtask

    task automatic open_window(input int len);
        start   = 1'b1;
        win_len = CNT_W'(len);
        tick();
        start   = 1'b0;
        win_len = CNT_W'($urandom);
    endtask

    task automatic send_range(input int from, input int to, input bit gaps);
        int  waited;
        bit  rdy;
        for (int i = from; i < to; i++) begin
            if (gaps) begin
                bus.in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            bus.in1        = WIDTH'(q1[i]);
            bus.in2        = WIDTH'(q2[i]);
            bus.mask       = MASK_W'(qm[i]);
            bus.approx_sum = (WIDTH + 1)'(qa[i]);
            bus.in_valid   = 1'b1;
            waited = 0;
            rdy    = 1'b0;
            while (!rdy && waited < 20) begin
                rdy = bus.in_ready;
                tick();
                waited++;
            end
            if (!rdy) check("accept_timeout", 0, 1);
        end
        bus.in_valid   = 1'b0;
        bus.in1        = WIDTH'($urandom);
        bus.approx_sum = (WIDTH + 1)'($urandom);
    endtask

    task automatic check_fields(input string tag);
        check({tag, "_samples"}, 64'(bus.rpt_samples), 64'(exp_samples));
        check({tag, "_err_cnt"}, 64'(bus.rpt_err_cnt), 64'(exp_err));
        check({tag, "_ed_sum"},  64'(bus.rpt_ed_sum),  64'(exp_sum));
        check({tag, "_ed_max"},  64'(bus.rpt_ed_max),  64'(exp_max));
        check({tag, "_mask"},    64'(bus.rpt_mask),    64'(exp_mask));
        check({tag, "_mask_chg"}, 64'(bus.rpt_mask_chg), 64'(exp_chg));
    endtask

    // Called right after the last accepting edge.
    task automatic expect_report(input string tag, input bit exact_latency, input int hold);
        int waited;
        compute_expected();
        if (exact_latency) begin
            check({tag, "_drain_rv"}, 64'(bus.rpt_valid), 0);
            tick();
            check({tag, "_lat_rv"}, 64'(bus.rpt_valid), 1);
        end else begin
            waited = 0;
            while (!bus.rpt_valid && waited < 50) begin
                tick();
                waited++;
            end
            check({tag, "_rv"}, 64'(bus.rpt_valid), 1);
        end
        check_fields(tag);
        for (int c = 0; c < hold; c++) begin
            bus.in_valid = 1'b1;
            start        = 1'b1;
            win_len      = CNT_W'(7);
            tick();
            check({tag, "_hold_rv"}, 64'(bus.rpt_valid), 1);
            check({tag, "_hold_rdy"}, 64'(bus.in_ready), 0);
            check_fields({tag, "_hold"});
        end
        bus.in_valid  = 1'b0;
        start         = 1'b0;
        bus.rpt_ready = 1'b1;
        tick();
        bus.rpt_ready = 1'b0;
        check({tag, "_done_rv"}, 64'(bus.rpt_valid), 0);
        check({tag, "_done_busy"}, 64'(busy), 0);
        clear_model();
    endtask

    initial begin
        int len, m, a, b, apx;
        rst_n          = 1'b0;
        start          = 1'b0;
        win_len        = '0;
        bus.in_valid   = 1'b0;
        bus.in1        = '0;
        bus.in2        = '0;
        bus.mask       = '0;
        bus.approx_sum = '0;
        bus.rpt_ready  = 1'b0;
        repeat (3) tick();

        check("rst_in_ready", 64'(bus.in_ready), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_rpt_valid", 64'(bus.rpt_valid), 0);
        exp_samples = 0; exp_err = 0; exp_sum = 0; exp_max = 0; exp_mask = 0; exp_chg = 0;
        check_fields("rst");
        rst_n = 1'b1;
        tick();

        // Two samples, one off by two.
        open_window(2);
        check("w1_busy", 64'(busy), 1);
        push(5, 6, 3, 11);
        push(5, 6, 3, 9);
        send_range(0, 2, 1'b0);
        expect_report("w1", 1'b1, 0);

        // Back-to-back with a mask change, then a stalled consumer.
        open_window(3);
        push(15, 15, 1, 30);
        push(15, 15, 1, 16);
        push(8, 8, 4, 16);
        send_range(0, 3, 1'b0);
        expect_report("w2", 1'b1, 5);
        check("w2_ignored_start", 64'(busy), 0);

        // Zero-length window request.
        open_window(0);
        check("zero_len_busy", 64'(busy), 0);
        check("zero_len_rdy", 64'(bus.in_ready), 0);

        // A second start mid-window must not alter the window.
        open_window(3);
        push(3, 4, 2, 7);
        push(9, 9, 2, 0);
        push(1, 2, 2, 5);
        send_range(0, 1, 1'b0);
        open_window(5);
        send_range(1, 3, 1'b1);
        expect_report("w3", 1'b1, 1);

        // Reset after one of four samples: no report afterwards.
        open_window(4);
        push(7, 7, 5, 3);
        send_range(0, 1, 1'b0);
        rst_n = 1'b0;
        #2;
        check("mid_rst_busy", 64'(busy), 0);
        tick();
        rst_n = 1'b1;
        clear_model();
        repeat (4) begin
            tick();
            check("post_rst_rv", 64'(bus.rpt_valid), 0);
        end
        check("post_rst_samples", 64'(bus.rpt_samples), 0);
        open_window(1);
        push(2, 3, 6, 5);
        send_range(0, 1, 1'b0);
        expect_report("w4", 1'b1, 0);

        // Randomized windows with input gaps and occasional mask changes.
        for (int w = 0; w < 8; w++) begin
            len = $urandom_range(1, 12);
            m   = $urandom_range(0, 7);
            for (int i = 0; i < len; i++) begin
                a = $urandom_range(0, 15);
                b = $urandom_range(0, 15);
                if ($urandom_range(0, 3) == 0) begin
                    apx = $urandom_range(0, 31);
                end else begin
                    apx = (a + b) & ~$urandom_range(0, 3);
                end
                push(a, b, ($urandom_range(0, 5) == 0) ? $urandom_range(0, 7) : m, apx);
            end
            open_window(len);
            send_range(0, len, 1'b1);
            expect_report($sformatf("rnd%0d", w), 1'b0, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
